// File: rtl/cache_mem_wb_sys.sv
// cache_mem_wb_sys: direct-mapped write-back write-allocate data cache with fixed-latency block memory
// clk, reset          : clock, synchronous active-high reset
// read_CPU, write_CPU : load / store request (both high = store)
// Bytesel             : 1 = byte access (lane from Addr_CPU), 0 = word access
// Wdata_CPU, Addr_CPU : store data, byte address
// Rdata_CPU           : load data, valid while a request is high and Stall_PC is low
// Stall_PC            : request not complete, hold the pipeline
// hit_count, miss_count : first-look hits / misses since reset
module cache_mem_wb_sys #(
    parameter int Word_Size   = 32,
    parameter int Block_Size  = 4,
    parameter int Num_Lines   = 4,
    parameter int Mem_Latency = 5,
    parameter int Mem_Words   = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_CPU,
    input  logic                 write_CPU,
    input  logic                 Bytesel,
    input  logic [Word_Size-1:0] Wdata_CPU,
    input  logic [Word_Size-1:0] Addr_CPU,
    output logic [Word_Size-1:0] Rdata_CPU,
    output logic                 Stall_PC,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);
    localparam int OB = $clog2(Word_Size / 8);
    localparam int WB = $clog2(Block_Size);
    localparam int IB = $clog2(Num_Lines);
    localparam int TW = Word_Size - OB - WB - IB;
    localparam int MA = $clog2(Mem_Words);
    localparam int CW = $clog2(Mem_Latency + 1);

    typedef enum logic [1:0] {IDLE, WBACK, REFILL, DONE} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt;
    logic [Word_Size-1:0] line [Num_Lines][Block_Size];
    logic [Word_Size-1:0] mem [Mem_Words];
    logic [TW-1:0]        tags [Num_Lines];
    logic [Num_Lines-1:0] valid, dirty;

    logic [OB-1:0]        boff;
    logic [WB-1:0]        woff;
    logic [IB-1:0]        idx;
    logic [TW-1:0]        tag;
    logic [OB+2:0]        sh;
    logic [MA-1:0]        nbase, vbase;
    logic [Word_Size-1:0] rword, nword;
    logic                 req, hit, last, store, fill, flush;

    assign boff  = Addr_CPU[OB-1:0];
    assign woff  = Addr_CPU[OB +: WB];
    assign idx   = Addr_CPU[OB+WB +: IB];
    assign tag   = Addr_CPU[Word_Size-1 -: TW];
    assign sh    = {boff, 3'b000};
    assign nbase = MA'({tag, idx, {WB{1'b0}}});
    assign vbase = MA'({tags[idx], idx, {WB{1'b0}}});

    assign req   = read_CPU | write_CPU;
    assign hit   = valid[idx] && tags[idx] == tag;
    assign last  = cnt == CW'(Mem_Latency - 1);
    assign store = write_CPU && hit && (state == IDLE || state == DONE);
    assign fill  = state == REFILL && last && !reset;
    assign flush = state == WBACK && last && !reset;

    assign rword     = line[idx][woff];
    assign nword     = Bytesel ? (rword & ~(Word_Size'(8'hff) << sh)) | (Word_Size'(Wdata_CPU[7:0]) << sh) : Wdata_CPU;
    assign Rdata_CPU = Bytesel ? Word_Size'(rword[sh +: 8]) : rword;
    assign Stall_PC  = state == WBACK || state == REFILL || (state == IDLE && req && !hit);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req && !hit) state_n = (valid[idx] && dirty[idx]) ? WBACK : REFILL;
            WBACK:   if (last) state_n = REFILL;
            REFILL:  if (last) state_n = DONE;
            DONE:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            valid      <= '0;
            dirty      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_n;
            cnt   <= ((state == WBACK || state == REFILL) && !last) ? cnt + CW'(1) : '0;
            if (state == IDLE && req) begin
                hit_count  <= hit ? hit_count + 32'd1 : hit_count;
                miss_count <= hit ? miss_count : miss_count + 32'd1;
            end
            if (fill) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
            if (store) dirty[idx] <= 1'b1;
        end
    end

    // Memory holds data XOR word address, so an all-zero power-up array reads back as Mem[i]=i.
    always_ff @(posedge clk) begin
        if (fill) begin
            tags[idx] <= tag;
            for (int w = 0; w < Block_Size; w++)
                line[idx][w] <= mem[nbase | MA'(w)] ^ Word_Size'(nbase | MA'(w));
        end else if (store && !reset) begin
            line[idx][woff] <= nword;
        end
        if (flush)
            for (int w = 0; w < Block_Size; w++)
                mem[vbase | MA'(w)] <= line[idx][w] ^ Word_Size'(vbase | MA'(w));
    end
endmodule

// File: tb/tb_cache_mem_wb_sys.sv
// tb_cache_mem_wb_sys: scoreboard bench for the write-back data cache subsystem
module tb_cache_mem_wb_sys;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read_CPU = 1'b0, write_CPU = 1'b0, Bytesel = 1'b0;
    logic [31:0] Wdata_CPU = '0, Addr_CPU = '0;
    logic [31:0] Rdata_CPU, hit_count, miss_count;
    logic        Stall_PC;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rd;
        bit          chk;
        int          stalls;
        int          hits;
        int          misses;
    } exp_t;

    exp_t q[$];

    cache_mem_wb_sys dut (
        .clk(clk), .reset(reset), .read_CPU(read_CPU), .write_CPU(write_CPU),
        .Bytesel(Bytesel), .Wdata_CPU(Wdata_CPU), .Addr_CPU(Addr_CPU),
        .Rdata_CPU(Rdata_CPU), .Stall_PC(Stall_PC),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input bit bs, input logic [31:0] a,
                          input logic [31:0] wd, input bit c, input logic [31:0] er,
                          input int st, input int h, input int m);
        exp_t e;
        bit   got;
        e.rd = er; e.chk = c; e.stalls = st; e.hits = h; e.misses = m;
        q.push_back(e);
        @(posedge clk); #1;
        read_CPU = rd; write_CPU = wr; Bytesel = bs; Addr_CPU = a; Wdata_CPU = wd;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (!Stall_PC) got = 1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout @%h: Stall_PC still high after 40 cycles, required low", a);
            void'(q.pop_back());
        end
        @(posedge clk); #1;
        read_CPU = 0; write_CPU = 0; Bytesel = 0;
    endtask

    task automatic abort_read(input logic [31:0] a);
        @(posedge clk); #1;
        read_CPU = 1; Bytesel = 0; Addr_CPU = a;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1;
        reset = 0; read_CPU = 0;
        @(negedge clk);
        check("abort_stall", {31'd0, Stall_PC}, 32'd0);
        check("abort_hits", hit_count, 32'd0);
        check("abort_misses", miss_count, 32'd0);
    endtask

    int   stall_cnt = 0;
    bit   cnt_pending = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (reset) begin
            stall_cnt = 0;
            cnt_pending = 0;
        end else begin
            if (cnt_pending) begin
                check("hit_count", hit_count, cur.hits);
                check("miss_count", miss_count, cur.misses);
                cnt_pending = 0;
            end
            if (read_CPU || write_CPU) begin
                if (Stall_PC) stall_cnt++;
                else if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_completion: addr %h with empty scoreboard", Addr_CPU);
                end else begin
                    cur = q.pop_front();
                    check("stall_cycles", stall_cnt, cur.stalls);
                    if (cur.chk) check("rdata", Rdata_CPU, cur.rd);
                    cnt_pending = 1;
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_stall", {31'd0, Stall_PC}, 32'd0);
        check("reset_hits", hit_count, 32'd0);
        check("reset_misses", miss_count, 32'd0);
        //      rd wr bs addr       wdata         chk rdata         st  h  m
        access(1, 0, 0, 32'h040, 32'h0,        1, 32'h00000010,  6, 0, 1);
        access(1, 0, 0, 32'h044, 32'h0,        1, 32'h00000011,  0, 1, 1);
        access(0, 1, 1, 32'h041, 32'h000000AB, 0, 32'h0,         0, 2, 1);
        access(1, 0, 1, 32'h041, 32'h0,        1, 32'h000000AB,  0, 3, 1);
        access(1, 0, 0, 32'h040, 32'h0,        1, 32'h0000AB10,  0, 4, 1);
        access(1, 0, 1, 32'h040, 32'h0,        1, 32'h00000010,  0, 5, 1);
        access(0, 1, 0, 32'h040, 32'hDEADBEEF, 0, 32'h0,         0, 6, 1);
        access(1, 0, 0, 32'h140, 32'h0,        1, 32'h00000050, 11, 6, 2);
        access(1, 0, 0, 32'h040, 32'h0,        1, 32'hDEADBEEF,  6, 6, 3);
        access(1, 0, 0, 32'h048, 32'h0,        1, 32'h00000012,  0, 7, 3);
        access(1, 1, 0, 32'h044, 32'h12345678, 0, 32'h0,         0, 8, 3);
        access(1, 0, 0, 32'h044, 32'h0,        1, 32'h12345678,  0, 9, 3);
        abort_read(32'h140);
        access(1, 0, 0, 32'h044, 32'h0,        1, 32'h00000011,  6, 0, 1);
        abort_read(32'h080);
        access(1, 0, 0, 32'h040, 32'h0,        1, 32'hDEADBEEF,  6, 0, 1);
        access(0, 1, 1, 32'h0D6, 32'h00000077, 0, 32'h0,         6, 0, 2);
        access(1, 0, 0, 32'h0D4, 32'h0,        1, 32'h00770035,  0, 1, 2);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
